// File: rtl/pc_fetch_if.sv
// Fetch-stage bundle: control/branch inputs, memory data in,
// fetch address and IF/ID register contents out.
interface pc_fetch_if #(
  parameter int tam = 8
);
  logic           inStall;
  logic           inBranchTaken;
  logic [tam-1:0] inBranchTarget;
  logic [tam-1:0] inInstruction;
  logic [tam-1:0] outPC;
  logic [tam-1:0] outIFID_Instr;
  logic [tam-1:0] outIFID_PC;
  logic           outIFID_Valid;
  logic           outHalted;

  modport master (
    input  inStall,
    input  inBranchTaken,
    input  inBranchTarget,
    input  inInstruction,
    output outPC,
    output outIFID_Instr,
    output outIFID_PC,
    output outIFID_Valid,
    output outHalted
  );

  modport slave (
    output inStall,
    output inBranchTaken,
    output inBranchTarget,
    output inInstruction,
    input  outPC,
    input  outIFID_Instr,
    input  outIFID_PC,
    input  outIFID_Valid,
    input  outHalted
  );
endinterface

// File: rtl/pc_fetch_stage.sv
// Instruction fetch: PC register, IF/ID register and halt tracking
// with stall, branch redirect (one bubble) and end-of-program halt.
module pc_fetch_stage #(
  parameter int tam       = 8,
  parameter int LAST_ADDR = 5
) (
  input  logic      clk,
  input  logic      reset_n,
  pc_fetch_if.master bus
);

  typedef struct packed {
    logic [tam-1:0] instr;
    logic [tam-1:0] pc;
    logic           valid;
  } if_id_t;

  localparam logic [0:0] RUN  = 1'b0;
  localparam logic [0:0] HALT = 1'b1;

  localparam logic [tam-1:0] LAST = tam'(LAST_ADDR);

  logic [tam-1:0] pc_q;
  logic [tam-1:0] pc_d;
  if_id_t         ifid_q;
  if_id_t         ifid_d;
  logic [0:0]     state_q;
  logic [0:0]     state_d;

  logic tgt_bad;
  logic halted;
  logic at_last;
  logic sel_br_ok;
  logic sel_br_bad;
  logic sel_stall;
  logic sel_halt;
  logic sel_last;
  logic sel_next;

  assign tgt_bad = bus.inBranchTarget > LAST;
  assign halted  = state_q == HALT;
  assign at_last = pc_q == LAST;

  // One-hot decode of the edge priority list
  assign sel_br_ok  = bus.inBranchTaken & ~tgt_bad;
  assign sel_br_bad = bus.inBranchTaken & tgt_bad;
  assign sel_stall  = ~bus.inBranchTaken & bus.inStall;
  assign sel_halt   = ~bus.inBranchTaken & ~bus.inStall
                    & halted;
  assign sel_last   = ~bus.inBranchTaken & ~bus.inStall
                    & ~halted & at_last;
  assign sel_next   = ~bus.inBranchTaken & ~bus.inStall
                    & ~halted & ~at_last;

  always_comb begin
    pc_d    = pc_q;
    ifid_d  = ifid_q;
    state_d = state_q;
    unique case (1'b1)
      sel_br_ok: begin
        pc_d         = bus.inBranchTarget;
        ifid_d.valid = 1'b0;
        state_d      = RUN;
      end
      sel_br_bad: begin
        ifid_d.valid = 1'b0;
        state_d      = HALT;
      end
      sel_stall: begin
        pc_d = pc_q;
      end
      sel_halt: begin
        ifid_d.valid = 1'b0;
      end
      sel_last: begin
        ifid_d.instr = bus.inInstruction;
        ifid_d.pc    = pc_q;
        ifid_d.valid = 1'b1;
        state_d      = HALT;
      end
      sel_next: begin
        ifid_d.instr = bus.inInstruction;
        ifid_d.pc    = pc_q;
        ifid_d.valid = 1'b1;
        pc_d         = pc_q + tam'(1);
      end
      default: begin
        pc_d = pc_q;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc_q    <= '0;
      ifid_q  <= '0;
      state_q <= RUN;
    end else begin
      pc_q    <= pc_d;
      ifid_q  <= ifid_d;
      state_q <= state_d;
    end
  end

  assign bus.outPC         = pc_q;
  assign bus.outIFID_Instr = ifid_q.instr;
  assign bus.outIFID_PC    = ifid_q.pc;
  assign bus.outIFID_Valid = ifid_q.valid;
  assign bus.outHalted     = halted;

endmodule

// File: tb/tb_pc_fetch_stage.sv
// Directed bench for pc_fetch_stage: expected outputs queued per
// step and popped after each edge for comparison.
module tb_pc_fetch_stage;

  typedef struct packed {
    logic [7:0] instr;
    logic [7:0] ifpc;
    logic       valid;
    logic       halted;
    logic [7:0] pc;
  } exp_t;

  logic clk;
  logic reset_n;
  logic [7:0] mem [8];
  exp_t q [$];
  int checks;
  int failures;

  pc_fetch_if #(.tam(8)) bus ();

  pc_fetch_stage #(.tam(8), .LAST_ADDR(5)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  assign bus.inInstruction = mem[bus.outPC[2:0]];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cmp(input string tag, input logic [7:0] obs,
                     input logic [7:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
    end
  endtask

  task automatic check_now(input string tag);
    exp_t e;
    if (q.size() == 0) begin
      checks++;
      failures++;
      $error("FAIL %s scoreboard empty observed=0 expected=1", tag);
    end else begin
      e = q.pop_front();
      cmp({tag, ".instr"}, bus.outIFID_Instr, e.instr);
      cmp({tag, ".ifpc"}, bus.outIFID_PC, e.ifpc);
      cmp({tag, ".valid"}, 8'(bus.outIFID_Valid), 8'(e.valid));
      cmp({tag, ".halt"}, 8'(bus.outHalted), 8'(e.halted));
      cmp({tag, ".pc"}, bus.outPC, e.pc);
    end
  endtask

  task automatic expect_out(input logic [7:0] i, input logic [7:0] p,
                            input logic v, input logic h,
                            input logic [7:0] pc);
    exp_t e;
    e.instr = i;
    e.ifpc = p;
    e.valid = v;
    e.halted = h;
    e.pc = pc;
    q.push_back(e);
  endtask

  task automatic step(input string tag, input logic st,
                      input logic br, input logic [7:0] tgt,
                      input logic [7:0] i, input logic [7:0] p,
                      input logic v, input logic h,
                      input logic [7:0] pc);
    bus.inStall = st;
    bus.inBranchTaken = br;
    bus.inBranchTarget = tgt;
    expect_out(i, p, v, h, pc);
    @(posedge clk);
    #1;
    check_now(tag);
  endtask

  initial begin
    checks = 0;
    failures = 0;
    mem[0] = 8'd3;  mem[1] = 8'd9;  mem[2] = 8'd6;  mem[3] = 8'd5;
    mem[4] = 8'd15; mem[5] = 8'd10; mem[6] = 8'd0;  mem[7] = 8'd0;
    bus.inStall = 1'b0;
    bus.inBranchTaken = 1'b0;
    bus.inBranchTarget = 8'd0;
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    expect_out(0, 0, 0, 0, 0);
    check_now("reset");
    @(negedge clk);
    reset_n = 1'b1;

    // straight-line run to halt
    step("run0", 0, 0, 0, 3, 0, 1, 0, 1);
    step("run1", 0, 0, 0, 9, 1, 1, 0, 2);
    step("run2", 0, 0, 0, 6, 2, 1, 0, 3);
    step("run3", 0, 0, 0, 5, 3, 1, 0, 4);
    step("run4", 0, 0, 0, 15, 4, 1, 0, 5);
    step("run5", 0, 0, 0, 10, 5, 1, 1, 5);
    step("halt0", 0, 0, 0, 10, 5, 0, 1, 5);
    step("halt1", 0, 0, 0, 10, 5, 0, 1, 5);

    // restart from 0 then stall on 6/2
    step("br0", 0, 1, 0, 10, 5, 0, 0, 0);
    step("r0", 0, 0, 0, 3, 0, 1, 0, 1);
    step("r1", 0, 0, 0, 9, 1, 1, 0, 2);
    step("r2", 0, 0, 0, 6, 2, 1, 0, 3);
    step("stall0", 1, 0, 0, 6, 2, 1, 0, 3);
    step("stall1", 1, 0, 0, 6, 2, 1, 0, 3);
    step("stall2", 1, 0, 0, 6, 2, 1, 0, 3);
    step("unstall", 0, 0, 0, 5, 3, 1, 0, 4);

    // branch to 1 while outPC=4
    step("br1", 0, 1, 1, 5, 3, 0, 0, 1);
    step("b1a", 0, 0, 0, 9, 1, 1, 0, 2);
    step("b1b", 0, 0, 0, 6, 2, 1, 0, 3);
    step("b1c", 0, 0, 0, 5, 3, 1, 0, 4);
    step("b1d", 0, 0, 0, 15, 4, 1, 0, 5);
    step("b1e", 0, 0, 0, 10, 5, 1, 1, 5);
    step("b1h", 0, 0, 0, 10, 5, 0, 1, 5);

    // branch out of halt
    step("br2", 0, 1, 2, 10, 5, 0, 0, 2);
    step("b2a", 0, 0, 0, 6, 2, 1, 0, 3);
    step("b2b", 0, 0, 0, 5, 3, 1, 0, 4);
    step("b2c", 0, 0, 0, 15, 4, 1, 0, 5);
    step("b2d", 0, 0, 0, 10, 5, 1, 1, 5);
    step("b2h", 0, 0, 0, 10, 5, 0, 1, 5);
    step("hstall", 1, 0, 0, 10, 5, 0, 1, 5);

    // stall+branch: branch wins
    step("stbr", 1, 1, 0, 10, 5, 0, 0, 0);
    step("sb0", 0, 0, 0, 3, 0, 1, 0, 1);
    step("sb1", 0, 0, 0, 9, 1, 1, 0, 2);

    // illegal target
    step("bad7", 0, 1, 7, 9, 1, 0, 1, 2);
    step("badh", 0, 0, 0, 9, 1, 0, 1, 2);
    step("bad255", 0, 1, 255, 9, 1, 0, 1, 2);

    // async reset mid-run
    step("br3", 0, 1, 0, 9, 1, 0, 0, 0);
    step("m0", 0, 0, 0, 3, 0, 1, 0, 1);
    step("m1", 0, 0, 0, 9, 1, 1, 0, 2);
    #2;
    reset_n = 1'b0;
    #1;
    expect_out(0, 0, 0, 0, 0);
    check_now("arst");
    @(posedge clk);
    #1;
    expect_out(0, 0, 0, 0, 0);
    check_now("arst_hold");
    @(negedge clk);
    reset_n = 1'b1;
    step("rel0", 0, 0, 0, 3, 0, 1, 0, 1);
    step("rel1", 0, 0, 0, 9, 1, 1, 0, 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pc_fetch_stage.md
# pc_fetch_stage

Instruction-fetch front end sitting directly upstream of the instruction memory: holds the program counter, drives the memory address, and registers the returned instruction into the IF/ID pipeline register for the decode stage. Supports pipeline stall, taken-branch redirect with bubble insertion, and halts cleanly after the last valid program address.

## Interface

Parameters:
- tam, 8, width of program counter, address and instruction word
- LAST_ADDR, 5, highest valid instruction-memory address

Ports:
- clk  input  1  system clock, rising-edge
- reset_n  input  1  asynchronous, active-low reset
- inStall  input  1  hold PC and IF/ID contents (decode stage busy)
- inBranchTaken  input  1  redirect fetch to inBranchTarget
- inBranchTarget  input  tam  branch destination address
- inInstruction  input  tam  instruction word from memory, combinational from outPC
- outPC  output  tam  fetch address to instruction memory (registered PC)
- outIFID_Instr  output  tam  registered instruction for decode
- outIFID_PC  output  tam  address of outIFID_Instr
- outIFID_Valid  output  1  outIFID_Instr is a real instruction, not a bubble
- outHalted  output  1  fetch stopped (end of program or illegal target)

## Operation

- State: PC register, IF/ID register (Instr, PC, Valid), halted flag. Two modes: RUN (halted=0), HALT (halted=1).
- Per rising edge, priority highest first:
  - inBranchTaken=1, target ≤ LAST_ADDR: PC <= target; IF/ID Valid <= 0 (bubble); halted <= 0. Applies in RUN or HALT, overrides inStall.
  - inBranchTaken=1, target > LAST_ADDR: PC unchanged; Valid <= 0; halted <= 1.
  - inStall=1: PC, IF/ID Instr/PC/Valid all hold; halted holds.
  - HALT: PC holds; Valid <= 0; Instr/PC hold.
  - RUN, PC < LAST_ADDR: IF/ID <= {inInstruction, PC, 1}; PC <= PC+1.
  - RUN, PC == LAST_ADDR: IF/ID <= {inInstruction, PC, 1}; PC holds; halted <= 1.
- PC increment is tam-bit unsigned; no wrap occurs because increment is blocked at LAST_ADDR.
- outPC is the PC register directly; no combinational path from inputs to any output.

## Timing

- Reset (async assert, any time incl. mid-branch/stall): PC=0, outIFID_Instr=0, outIFID_PC=0, outIFID_Valid=0, outHalted=0. Deassertion synchronized by the next rising edge; first fetch occurs on the first edge with reset_n=1.
- Latency: instruction at address A appears on outIFID_Instr with Valid=1 one edge after outPC=A (memory is combinational on address).
- Throughput: one instruction per cycle when unstalled.
- Branch penalty: one bubble; edge with inBranchTaken captures Valid=0, next edge captures mem[target] with Valid=1.
- Stall: every output identical to previous cycle for each stalled edge; release resumes without loss or duplication.
- Simultaneous stall+branch: branch wins; the stalled IF/ID content is discarded.
- outHalted rises on the same edge that captures mem[LAST_ADDR]; Valid drops one edge later.

## Test plan

- Memory {3,9,6,5,15,10}, no stall/branch, release reset -> outIFID_Instr sequence 3,9,6,5,15,10 with outIFID_PC 0..5, Valid=1 for six edges, then Valid=0, outHalted=1, outPC stays 5.
- Stall asserted for 3 edges while outIFID_Instr=6 (PC field 2) -> outputs frozen at 6/2/Valid=1 and outPC=3 for 3 cycles; next edge gives 5/3.
- Branch to 1 on edge when outPC=4 -> one bubble (Valid=0), then 9/1, 6/2, ...; address 4 never delivered Valid.
- Branch to 2 while halted -> outHalted=0, bubble, then 6,5,15,10, halt again.
- Branch target 7 (> LAST_ADDR) -> Valid=0, outHalted=1, outPC unchanged; stall+branch to 0 same edge -> branch taken, bubble, then 3.
- reset_n pulled low mid-run (asynchronously, between edges) -> all outputs zero immediately; on release, fetch restarts at address 0 delivering 3.
